hit_event_arbiter: RTL and testbench
====================================

Name: hit_event_arbiter

Overview:
- Collects single-cycle drum-hit pulses from several conditioned input channels (don/ka per player, each already debounced and one-pulsed upstream).
- Holds each hit as a pending request and ages it per video frame.
- Serialises pending hits round-robin onto one valid/ready event port that feeds the note-judge logic.
- Drops hits that are never consumed within the allowed frame window.

Parameters:
- N_CH, 4, number of hit input channels.
- CH_W, 2, width of channel index; equals clog2(N_CH).
- STALE_FRAMES, 2, vsync strobes a non-offered pending hit survives before it is dropped; legal range 1..3.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; synchronous, active-low
- hit_pulse  in  N_CH  one-cycle hit strobes; bit i is channel i
- vsync  in  1  one-cycle frame strobe
- ev_valid  out  1  event offered to consumer
- ev_ch  out  CH_W  channel of offered event
- ev_age  out  2  vsync count the offered hit has waited
- ev_ready  in  1  consumer accepts event
- pending  out  N_CH  per-channel pending flags (registered)
- drop_cnt  out  8  saturating count of lost hits

Behaviour:
- Reset (rst_n low at posedge):
  - pending=0, all ages=0, ev_valid=0, ev_ch=0, ev_age=0, drop_cnt=0.
  - RR pointer=0, state=IDLE.
  - Reset overrides every simultaneous event and may occur mid-offer; the offered event is discarded without counting.
- Capture:
  - hit_pulse[i] at edge E sets pending[i] with age 0, visible after E.
  - A hit on a channel that is already pending and not offered is merged: the flag stays, the age is unchanged, and drop_cnt increments.
- Ageing, on a vsync edge:
  - Each pending, non-offered channel increments its age.
  - If the incremented age equals STALE_FRAMES, pending[i] clears, its age resets to 0, and that channel counts one drop.
  - The offered channel increments its age (saturating at 3) but is never dropped while offered.
- drop_cnt:
  - Increments by the total drops and merges in the cycle, which may be several channels at once.
  - Saturates at 255 and never wraps.
- FSM states are IDLE and OFFER.
  - IDLE: if any pending bit is set, pick the first pending channel at or after the RR pointer, wrapping modulo N_CH. Register ev_valid=1, ev_ch=pick, ev_age=age[pick], and go to OFFER. If nothing is pending, stay in IDLE.
  - Latency from hit_pulse to ev_valid is 2 edges minimum: capture edge plus pick edge.
  - OFFER: ev_ch and ev_age are held stable until the handshake; ev_age may only change by the vsync increment.
  - OFFER, on ev_valid & ev_ready at an edge: clear pending[ev_ch], set RR pointer=(ev_ch+1) mod N_CH, set ev_valid=0, and return to IDLE.
  - There is one bubble cycle between consecutive events.
- Simultaneous events:
  - Hit on the offered channel during the handshake edge: the old hit is consumed, and a new pending is set with age 0. No merge is counted.
  - Hit on the offered channel without a handshake: merge; counted.
  - vsync and hit on the same non-pending channel: the set wins with age 0, and no ageing applies.
  - vsync, handshake and stale drop in one edge: all apply independently.
- ev_ready while ev_valid=0 is ignored.
- The pending output reflects the registered flags, including the offered channel.

Decomposition:
- Shared package taiko_input_pkg holds:
  - channel constants CH_DON_P1=0, CH_KA_P1=1, CH_DON_P2=2, CH_KA_P2=3;
  - the arb_state_t enum (IDLE, OFFER);
  - DROP_CNT_W=8.
- One sub-module is natural: rr_pick. It is combinational; inputs are a request vector and a pointer, outputs are a found flag and an index. It is reused by later arbitration blocks.

Test Plan:
- Reset, then a pulse on ch2 at edge 1 with ev_ready=1 → pending=0100 after edge 1; ev_valid=1, ev_ch=2, ev_age=0 after edge 2; pending=0000 and ev_valid=0 after edge 3.
- Pulses on ch0, ch1 and ch3 in the same cycle, ev_ready=1 → events offered in order 0, 1, 3, each separated by one bubble cycle; RR pointer ends at 0.
- Pulse on ch1 with ev_ready=0, then two vsync strobes → ch1 stays offered, ev_age goes to 2, drop_cnt stays 0. A pulse on ch3 before those strobes is dropped at the 2nd vsync: pending[3]=0, drop_cnt=1.
- Second pulse on a pending, offered ch0 with ev_ready=0 → drop_cnt +1. A pulse on ch0 in the handshake cycle → ch0 is re-offered next with ev_age=0.
- Force 300 merges → drop_cnt holds at 255.
- rst_n low for one edge while in OFFER with ch2 valid → ev_valid=0, pending=0, drop_cnt=0 on the next cycle; a following ch0 pulse is offered normally.

Source files
------------

// File: rtl/taiko_input_pkg.sv
// Shared definitions for the drum-hit input path.
// Contents: channel index constants, the arbiter state enum, drop counter width
//           and a small saturating 2-bit age increment helper.
package taiko_input_pkg;

  localparam int CH_DON_P1  = 0;
  localparam int CH_KA_P1   = 1;
  localparam int CH_DON_P2  = 2;
  localparam int CH_KA_P2   = 3;

  localparam int DROP_CNT_W = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

  // Frame-age increment that sticks at 3 instead of wrapping.
  function automatic logic [1:0] sat_inc2(input logic [1:0] a, input logic inc);
    return (inc && (a != 2'd3)) ? a + 2'd1 : a;
  endfunction

endpackage

// File: rtl/hit_event_arbiter_rr_pick.sv
// Round-robin picker: first set request at or after ptr_i, wrapping modulo N.
// Ports: req_i request vector, ptr_i start index; found_o any request set,
//        idx_o winning index (0 when nothing is found). Purely combinational.
module rr_pick #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic         found_o,
  output logic [W-1:0] idx_o
);

  logic [W-1:0] cand;

  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    cand    = '0;
    for (int k = 0; k < N; k++) begin
      cand = W'((int'(ptr_i) + k) % N);
      if (!found_o && req_i[cand]) begin
        found_o = 1'b1;
        idx_o   = cand;
      end
    end
  end

endmodule

// File: rtl/hit_event_arbiter.sv
// Hit event arbiter: latches per-channel hit pulses as pending requests, ages
// them on vsync, drops stale ones and serialises the rest round-robin onto a
// valid/ready event port. Ports: hit_pulse/vsync in; ev_valid/ev_ch/ev_age out
// with ev_ready in; pending flags and a saturating drop_cnt out.
module hit_event_arbiter
  import taiko_input_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CH_W         = 2,
  parameter int STALE_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       hit_pulse,
  input  logic                  vsync,
  output logic                  ev_valid,
  output logic [CH_W-1:0]       ev_ch,
  output logic [1:0]            ev_age,
  input  logic                  ev_ready,
  output logic [N_CH-1:0]       pending,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  // Up to two losses per channel per cycle (merge + stale drop).
  localparam int LOST_W = CH_W + 2;

  arb_state_t                state_q, state_d;
  logic [N_CH-1:0]           pend_q, pend_d;
  logic [N_CH-1:0][1:0]      age_q, age_d;
  logic                      ev_valid_q, ev_valid_d;
  logic [CH_W-1:0]           ev_ch_q, ev_ch_d;
  logic [1:0]                ev_age_q, ev_age_d;
  logic [CH_W-1:0]           rr_q, rr_d;
  logic [DROP_CNT_W-1:0]     drop_q, drop_d;

  logic                      found;
  logic [CH_W-1:0]           pick;
  logic                      hs;
  logic                      pick_now;
  logic [N_CH-1:0]           held;
  logic [N_CH-1:0]           cons;
  logic [1:0]                age_inc;
  logic [LOST_W-1:0]         lost;
  logic [DROP_CNT_W:0]       drop_sum;

  rr_pick #(.N(N_CH), .W(CH_W)) u_rr_pick (
    .req_i   (pend_q),
    .ptr_i   (rr_q),
    .found_o (found),
    .idx_o   (pick)
  );

  assign hs       = ev_valid_q & ev_ready;
  assign pick_now = (state_q == IDLE) & found;

  // State register together with the datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pend_q     <= '0;
      age_q      <= '0;
      ev_valid_q <= 1'b0;
      ev_ch_q    <= '0;
      ev_age_q   <= '0;
      rr_q       <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      age_q      <= age_d;
      ev_valid_q <= ev_valid_d;
      ev_ch_q    <= ev_ch_d;
      ev_age_q   <= ev_age_d;
      rr_q       <= rr_d;
      drop_q     <= drop_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (found) state_d = OFFER;
      OFFER:   if (hs)    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pending flags, ageing and loss accounting.
  // A channel being picked this edge is treated as already offered, so it is
  // never dropped in the same edge that it is handed to the consumer.
  always_comb begin
    pend_d  = pend_q;
    age_d   = age_q;
    held    = '0;
    cons    = '0;
    age_inc = '0;
    lost    = '0;
    if (state_q == OFFER) held[ev_ch_q] = 1'b1;
    if (pick_now)         held[pick]    = 1'b1;
    if (hs)               cons[ev_ch_q] = 1'b1;
    for (int i = 0; i < N_CH; i++) begin
      if (hit_pulse[i] && (!pend_q[i] || cons[i])) begin
        // Fresh capture, or re-arm of the channel consumed this edge.
        pend_d[i] = 1'b1;
        age_d[i]  = 2'd0;
      end else if (cons[i]) begin
        pend_d[i] = 1'b0;
        age_d[i]  = 2'd0;
      end else begin
        if (hit_pulse[i]) lost = lost + LOST_W'(1);  // merged into pending hit
        if (pend_q[i] && !held[i] && vsync) begin
          age_inc = age_q[i] + 2'd1;
          if (age_inc == 2'(STALE_FRAMES)) begin
            pend_d[i] = 1'b0;
            age_d[i]  = 2'd0;
            lost      = lost + LOST_W'(1);
          end else begin
            age_d[i]  = age_inc;
          end
        end
      end
    end
    drop_sum = {1'b0, drop_q} + (DROP_CNT_W+1)'(lost);
    drop_d   = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
  end

  // Event port registers and round-robin pointer.
  always_comb begin
    ev_valid_d = ev_valid_q;
    ev_ch_d    = ev_ch_q;
    ev_age_d   = ev_age_q;
    rr_d       = rr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ev_valid_d = 1'b1;
          ev_ch_d    = pick;
          ev_age_d   = sat_inc2(age_q[pick], vsync);
        end
      end
      OFFER: begin
        if (hs) begin
          ev_valid_d = 1'b0;
          rr_d       = (ev_ch_q == CH_W'(N_CH-1)) ? '0 : ev_ch_q + CH_W'(1);
        end else begin
          ev_age_d   = sat_inc2(ev_age_q, vsync);
        end
      end
      default: ;
    endcase
  end

  assign ev_valid = ev_valid_q;
  assign ev_ch    = ev_ch_q;
  assign ev_age   = ev_age_q;
  assign pending  = pend_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_hit_event_arbiter.sv
module tb_hit_event_arbiter;
  import taiko_input_pkg::*;

  localparam int STALE = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] hit_pulse = '0;
  logic       vsync = 1'b0;
  logic       ev_ready = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_ch;
  logic [1:0] ev_age;
  logic [3:0] pending;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit m_pend[4];
  int m_age[4];
  bit m_val;
  int m_ch, m_evage, m_drop, m_rr;

  hit_event_arbiter #(.N_CH(4), .CH_W(2), .STALE_FRAMES(STALE)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .hit_pulse (hit_pulse),
    .vsync     (vsync),
    .ev_valid  (ev_valid),
    .ev_ch     (ev_ch),
    .ev_age    (ev_age),
    .ev_ready  (ev_ready),
    .pending   (pending),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  // One clock edge of the behavioural model, from the rules of the block.
  task automatic model_edge(input logic [3:0] h, input logic v, input logic r, input logic rs);
    bit np[4];
    int na[4];
    int lost, pick, held;
    bit hs, picking;
    if (!rs) begin
      for (int i = 0; i < 4; i++) begin m_pend[i] = 0; m_age[i] = 0; end
      m_val = 0; m_ch = 0; m_evage = 0; m_drop = 0; m_rr = 0;
      return;
    end
    hs = m_val && r;
    picking = 0; pick = 0;
    if (!m_val)
      for (int k = 0; k < 4; k++) begin
        int c;
        c = (m_rr + k) % 4;
        if (!picking && m_pend[c]) begin picking = 1; pick = c; end
      end
    held = m_val ? m_ch : (picking ? pick : -1);
    lost = 0;
    for (int i = 0; i < 4; i++) begin
      np[i] = m_pend[i]; na[i] = m_age[i];
      if (hs && i == m_ch) begin
        np[i] = h[i]; na[i] = 0;
      end else if (h[i] && !m_pend[i]) begin
        np[i] = 1; na[i] = 0;
      end else begin
        if (h[i]) lost++;
        if (m_pend[i] && i != held && v) begin
          na[i]++;
          if (na[i] == STALE) begin np[i] = 0; na[i] = 0; lost++; end
        end
      end
    end
    if (hs) begin
      m_val = 0; m_rr = (m_ch + 1) % 4;
    end else if (m_val) begin
      m_evage = (m_evage + int'(v) > 3) ? 3 : m_evage + int'(v);
    end else if (picking) begin
      m_val = 1; m_ch = pick;
      m_evage = (m_age[pick] + int'(v) > 3) ? 3 : m_age[pick] + int'(v);
    end
    for (int i = 0; i < 4; i++) begin m_pend[i] = np[i]; m_age[i] = na[i]; end
    m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
  endtask

  // Drive one cycle of inputs, let the edge happen, sample 1 time unit later.
  task automatic tick(input logic [3:0] h, input logic v, input logic r, input logic rs);
    hit_pulse = h; vsync = v; ev_ready = r; rst_n = rs;
    @(posedge clk);
    model_edge(h, v, r, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(4'b1111, 1'b1, 1'b1, 1'b0);
    checks++; if (pending !== 4'b0000) begin errors++; $display("FAIL reset_pending got %b expected 0000", pending); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL reset_ev_valid got %b expected 0", ev_valid); end
    checks++; if (ev_ch !== 2'd0) begin errors++; $display("FAIL reset_ev_ch got %0d expected 0", ev_ch); end
    checks++; if (ev_age !== 2'd0) begin errors++; $display("FAIL reset_ev_age got %0d expected 0", ev_age); end
    checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop_cnt got %0d expected 0", drop_cnt); end
  endtask

  task automatic test_single();
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b1, 1'b1);
    checks++; if (pending !== 4'b0100) begin errors++; $display("FAIL single_capture got %b expected 0100", pending); end
    checks++; if (ev_valid !== 1'b0) begin errors++; $display("FAIL single_no_early_valid got %b expected 0", ev_valid); end
    tick(4'b0000, 1'b0, 1'b1, 1'b1);
    checks++; if ({ev_valid, ev_ch, ev_age} !== {1'b1, 2'd2, 2'd0}) begin errors++;
      $display("FAIL single_offer got v=%b ch=%0d age=%0d expected v=1 ch=2 age=0", ev_valid, ev_ch, ev_age); end
    tick(4'b0000, 1'b0, 1'b1, 1'b1);
    checks++; if ({pending, ev_valid} !== {4'b0000, 1'b0}) begin errors++;
      $display("FAIL single_consume got pend=%b v=%b expected pend=0000 v=0", pending, ev_valid); end
  endtask

  task automatic test_round_robin();
    logic [6:0] exp_v;
    int exp_ch[3];
    int n;
    exp_v = 7'b1010100;
    exp_ch[0] = CH_DON_P1; exp_ch[1] = CH_KA_P1; exp_ch[2] = CH_KA_P2;
    n = 0;
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b1011, 1'b0, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) begin
      tick(4'b0000, 1'b0, 1'b1, 1'b1);
      checks++; if (ev_valid !== exp_v[6-c]) begin errors++;
        $display("FAIL rr_valid_cycle%0d got %b expected %b", c, ev_valid, exp_v[6-c]); end
      if (exp_v[6-c] && n < 3) begin
        checks++; if (ev_ch !== 2'(exp_ch[n])) begin errors++;
          $display("FAIL rr_order%0d got %0d expected %0d", n, ev_ch, exp_ch[n]); end
        n++;
      end
    end
    // Pointer should be back at 0: with ch0 and ch3 requesting, ch0 wins.
    tick(4'b1001, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch} !== {1'b1, 2'd0}) begin errors++;
      $display("FAIL rr_ptr_wrap got v=%b ch=%0d expected v=1 ch=0", ev_valid, ev_ch); end
  endtask

  task automatic test_stale();
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch} !== {1'b1, 2'd1}) begin errors++;
      $display("FAIL stale_offer got v=%b ch=%0d expected v=1 ch=1", ev_valid, ev_ch); end
    tick(4'b1000, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b1, 1'b0, 1'b1);
    checks++; if (ev_age !== 2'd1) begin errors++; $display("FAIL stale_age1 got %0d expected 1", ev_age); end
    tick(4'b0000, 1'b1, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch, ev_age} !== {1'b1, 2'd1, 2'd2}) begin errors++;
      $display("FAIL stale_offer_kept got v=%b ch=%0d age=%0d expected v=1 ch=1 age=2", ev_valid, ev_ch, ev_age); end
    checks++; if (pending !== 4'b0010) begin errors++; $display("FAIL stale_pending got %b expected 0010", pending); end
    checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL stale_drop got %0d expected 1", drop_cnt); end
  endtask

  task automatic test_merge();
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0001, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0001, 1'b0, 1'b0, 1'b1);
    checks++; if ({pending, drop_cnt} !== {4'b0001, 8'd1}) begin errors++;
      $display("FAIL merge_offered got pend=%b drop=%0d expected pend=0001 drop=1", pending, drop_cnt); end
    tick(4'b0001, 1'b0, 1'b1, 1'b1);
    checks++; if ({ev_valid, pending, drop_cnt} !== {1'b0, 4'b0001, 8'd1}) begin errors++;
      $display("FAIL merge_hs_rearm got v=%b pend=%b drop=%0d expected v=0 pend=0001 drop=1", ev_valid, pending, drop_cnt); end
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch, ev_age} !== {1'b1, 2'd0, 2'd0}) begin errors++;
      $display("FAIL merge_reoffer got v=%b ch=%0d age=%0d expected v=1 ch=0 age=0", ev_valid, ev_ch, ev_age); end
  endtask

  task automatic test_saturate();
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0010, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 300; i++) begin
      tick(4'b0010, 1'b0, 1'b0, 1'b1);
      if (i == 253) begin
        checks++; if (drop_cnt !== 8'd254) begin errors++; $display("FAIL sat_254 got %0d expected 254", drop_cnt); end
      end
    end
    checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL sat_255 got %0d expected 255", drop_cnt); end
    checks++; if ({ev_valid, ev_ch, pending} !== {1'b1, 2'd1, 4'b0010}) begin errors++;
      $display("FAIL sat_state got v=%b ch=%0d pend=%b expected v=1 ch=1 pend=0010", ev_valid, ev_ch, pending); end
  endtask

  task automatic test_reset_mid();
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    tick(4'b0100, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    tick(4'b0100, 1'b0, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch, drop_cnt} !== {1'b1, 2'd2, 8'd1}) begin errors++;
      $display("FAIL rstmid_pre got v=%b ch=%0d drop=%0d expected v=1 ch=2 drop=1", ev_valid, ev_ch, drop_cnt); end
    tick(4'b0000, 1'b0, 1'b1, 1'b0);
    checks++; if ({ev_valid, pending, drop_cnt} !== {1'b0, 4'b0000, 8'd0}) begin errors++;
      $display("FAIL rstmid_clear got v=%b pend=%b drop=%0d expected v=0 pend=0000 drop=0", ev_valid, pending, drop_cnt); end
    tick(4'b0001, 1'b0, 1'b0, 1'b1);
    tick(4'b0000, 1'b0, 1'b0, 1'b1);
    checks++; if ({ev_valid, ev_ch, ev_age} !== {1'b1, 2'd0, 2'd0}) begin errors++;
      $display("FAIL rstmid_after got v=%b ch=%0d age=%0d expected v=1 ch=0 age=0", ev_valid, ev_ch, ev_age); end
  endtask

  task automatic test_random();
    logic [3:0] h;
    logic [3:0] mp;
    logic v, r, rs;
    tick(4'b0000, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) h[i] = ($urandom_range(0, 3) == 0);
      v  = ($urandom_range(0, 3) == 0);
      r  = ($urandom_range(0, 2) == 0);
      rs = ($urandom_range(0, 299) != 0);
      tick(h, v, r, rs);
      for (int i = 0; i < 4; i++) mp[i] = m_pend[i];
      checks++; if (pending !== mp) begin errors++;
        $display("FAIL rand_pending cyc%0d got %b expected %b", c, pending, mp); end
      checks++; if (ev_valid !== m_val) begin errors++;
        $display("FAIL rand_ev_valid cyc%0d got %b expected %b", c, ev_valid, m_val); end
      checks++; if (ev_ch !== 2'(m_ch)) begin errors++;
        $display("FAIL rand_ev_ch cyc%0d got %0d expected %0d", c, ev_ch, m_ch); end
      checks++; if (ev_age !== 2'(m_evage)) begin errors++;
        $display("FAIL rand_ev_age cyc%0d got %0d expected %0d", c, ev_age, m_evage); end
      checks++; if (drop_cnt !== 8'(m_drop)) begin errors++;
        $display("FAIL rand_drop_cnt cyc%0d got %0d expected %0d", c, drop_cnt, m_drop); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_stale();
    test_merge();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
